min_index_seq: RTL and testbench
================================

# min_index_seq

Sequential, parametrised minimum/maximum finder over N channel values; the successor of the 6-input combinational min-index tree used for cube colour classification. A start pulse captures all N values and a per-channel enable mask. The block then scans one channel per clock and reports the winning channel index, its value and whether any channel was eligible. It sits between the colour-distance computation and the cube-state encoder, and frees the design from the fixed 6-channel comparator tree.

## Interface
- N, default 6: number of channels (N ≥ 2).
- W, default 16: width of each channel value, unsigned.
- IW, default $clog2(N): index width (≥ 1).
- FIND_MAX, default 0: 0 selects the minimum, 1 selects the maximum.
- TIE_LAST, default 0: on equal values, 0 keeps the lowest index and 1 takes the highest index.

- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE or DONE.
- values  in  N*W  flat bus; channel i occupies bits [i*W +: W].
- enable  in  N  per-channel eligibility; bit i = 1 means channel i participates.
- busy  out  1  high while in SCAN.
- done  out  1  high while in DONE.
- found  out  1  at least one enabled channel in the last completed scan.
- min_index  out  IW  winning channel index of the last completed scan.
- min_value  out  W  winning value of the last completed scan.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE → SCAN: on start=1.
  - values and enable are copied into internal registers.
  - Counter i is set to 0, and best_valid is set to 0.
- SCAN runs one channel per cycle. Channel i is taken as the new best when enable_r[i]=1 and any of these holds:
  - best_valid=0;
  - the value is strictly better than best (less than, or greater than when FIND_MAX=1);
  - the value equals best and TIE_LAST=1.
- When a channel is taken, best_value and best_index are updated and best_valid is set to 1.
- SCAN → DONE: after channel N-1 is examined.
  - On that same edge, found, min_index and min_value are loaded from the final best_valid, best_index and best_value.
  - This includes channel N-1's own update.
- DONE → SCAN: on start=1, with a fresh capture as described for IDLE. Without start, the block stays in DONE indefinitely.
- start is ignored in SCAN; no restart and no abort.
- Changes on values and enable after capture have no effect on the scan in progress.
- Result outputs are written only on the SCAN→DONE edge and hold the previous result throughout a new scan.
- No enabled channels: found=0, min_index=0, min_value=0.
- Comparison is unsigned and W bits wide; there is no overflow path.
- Counter i wraps or stops at N-1. It must never index past N-1, including when N is not a power of two.

## Timing
- Reset (reset_n=0, asynchronous):
  - the FSM goes to IDLE;
  - busy, done, found, min_index and min_value are 0;
  - internal registers are cleared.
- Reset mid-SCAN discards the scan. No done is produced.
- Latency: if start is sampled at edge t, busy=1 from edge t through edge t+N-1 (N cycles). done=1 and the results are valid from edge t+N.
- Back-to-back: start held high in DONE restarts on the next edge, which gives a throughput of N+1 cycles per result.
- busy and done are registered, mutually exclusive, and both 0 only in IDLE.

## Test plan
- Reset check: hold reset_n=0, then release and apply no start.
  - Required: all outputs 0 and busy=0.
  - Then assert reset_n=0 asynchronously in the middle of a scan: outputs clear immediately and no done pulse follows.
- Basic minimum, N=6, W=8, FIND_MAX=0: values={40,12,99,12,7,50} (channel 0 first), enable=6'b111111, start pulsed.
  - Required: busy for 6 cycles, then done=1, found=1, min_index=4, min_value=7.
- Ties and masking: same values with enable=6'b101111 (channel 4 disabled).
  - With TIE_LAST=0: min_index=1, min_value=12.
  - With TIE_LAST=1: min_index=3.
- All disabled, then maximum mode:
  - enable=0 gives found=0, min_index=0, min_value=0.
  - FIND_MAX=1 with values={3,200,200,9,0,1} and all enabled gives min_index=1 (TIE_LAST=0), min_value=200.
- Capture and ignore rules:
  - Change values and pulse start during SCAN: the result reflects the captured values only, and done appears exactly N cycles after the original start.
  - Hold start in DONE: a new scan begins and the old result stays visible until the new done.
- Non-power-of-two depth: N=5, IW=3, values={9,8,7,6,5}.
  - Required: min_index=4 after 5 busy cycles, with no out-of-range access (assertion on i ≤ N-1).

Source files
------------

// File: rtl/min_index_seq.sv
// Sequential min/max channel finder.
// Ports:
//   clock, reset_n    : clock and async active-low reset
//   start             : capture values/enable and begin a scan
//   values            : N channels of W bits, channel i at [i*W +: W]
//   enable            : per-channel participation mask
//   busy, done        : scan in progress / result ready
//   found             : at least one enabled channel in the last scan
//   min_index         : winning channel index of the last scan
//   min_value         : winning value of the last scan
`timescale 1ns/1ps
module min_index_seq #(
    parameter int N        = 6,
    parameter int W        = 16,
    parameter int IW       = $clog2(N),
    parameter bit FIND_MAX = 1'b0,
    parameter bit TIE_LAST = 1'b0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [N*W-1:0] values,
    input  logic [N-1:0]  enable,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [IW-1:0] min_index,
    output logic [W-1:0]  min_value
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t         state;
    state_t         state_nx;
    logic           capture;

    logic [W-1:0]   values_r [N];
    logic [N-1:0]   enable_r;
    logic [IW-1:0]  cnt;
    logic           best_valid;
    logic [IW-1:0]  best_index;
    logic [W-1:0]   best_value;

    logic [W-1:0]   cur_value;
    logic           cur_en;
    logic           better;
    logic           tie;
    logic           take;
    logic           last;
    logic           nxt_valid;
    logic [IW-1:0]  nxt_index;
    logic [W-1:0]   nxt_value;

    // cnt never exceeds LAST, so these selects stay in range
    assign cur_value = values_r[cnt];
    assign cur_en    = enable_r[cnt];
    assign last      = (cnt == LAST);

    always_comb begin
        better = FIND_MAX ? (cur_value > best_value)
                          : (cur_value < best_value);
        tie    = TIE_LAST && (cur_value == best_value);
        take   = cur_en && (!best_valid || better || tie);
    end

    // Best-so-far including the channel under examination;
    // this is what lands in the outputs on the final edge.
    always_comb begin
        nxt_valid = best_valid;
        nxt_index = best_index;
        nxt_value = best_value;
        if (take) begin
            nxt_valid = 1'b1;
            nxt_index = cnt;
            nxt_value = cur_value;
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                    capture  = 1'b1;
                end
            end
            SCAN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx = SCAN;
                    capture  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            min_index  <= '0;
            min_value  <= '0;
            enable_r   <= '0;
            cnt        <= '0;
            best_valid <= 1'b0;
            best_index <= '0;
            best_value <= '0;
            for (int k = 0; k < N; k++) begin
                values_r[k] <= '0;
            end
        end else begin
            busy <= (state_nx == SCAN);
            done <= (state_nx == DONE);
            if (capture) begin
                for (int k = 0; k < N; k++) begin
                    values_r[k] <= values[k*W +: W];
                end
                enable_r   <= enable;
                cnt        <= '0;
                best_valid <= 1'b0;
                best_index <= '0;
                best_value <= '0;
            end else if (state == SCAN) begin
                cnt        <= last ? '0 : cnt + IW'(1);
                best_valid <= nxt_valid;
                best_index <= nxt_index;
                best_value <= nxt_value;
                if (last) begin
                    found     <= nxt_valid;
                    min_index <= nxt_valid ? nxt_index : '0;
                    min_value <= nxt_valid ? nxt_value : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_min_index_seq.sv
// Testbench for min_index_seq: four parameter variants
// driven side by side and checked against a reference model.
`timescale 1ns/1ps
module tb_min_index_seq;

    typedef struct packed {
        logic       f;
        logic [2:0] i;
        logic [7:0] v;
    } res_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        start5 = 1'b0;
    logic [47:0] values6 = '0;
    logic [5:0]  enable6 = '0;
    logic [39:0] values5 = '0;
    logic [4:0]  enable5 = '0;

    logic       busy_a, done_a, found_a;
    logic [2:0] idx_a;
    logic [7:0] val_a;
    logic       busy_b, done_b, found_b;
    logic [2:0] idx_b;
    logic [7:0] val_b;
    logic       busy_c, done_c, found_c;
    logic [2:0] idx_c;
    logic [7:0] val_c;
    logic       busy_d, done_d, found_d;
    logic [2:0] idx_d;
    logic [7:0] val_d;

    int errors = 0;
    int checks = 0;

    res_t e_min = '0;
    res_t e_tie = '0;
    res_t e_max = '0;
    res_t e_n5  = '0;

    always #5 clock = ~clock;

    min_index_seq #(.N(6), .W(8), .FIND_MAX(1'b0), .TIE_LAST(1'b0)) dut_min (
        .clock(clock), .reset_n(reset_n), .start(start),
        .values(values6), .enable(enable6),
        .busy(busy_a), .done(done_a), .found(found_a),
        .min_index(idx_a), .min_value(val_a));

    min_index_seq #(.N(6), .W(8), .FIND_MAX(1'b0), .TIE_LAST(1'b1)) dut_tie (
        .clock(clock), .reset_n(reset_n), .start(start),
        .values(values6), .enable(enable6),
        .busy(busy_b), .done(done_b), .found(found_b),
        .min_index(idx_b), .min_value(val_b));

    min_index_seq #(.N(6), .W(8), .FIND_MAX(1'b1), .TIE_LAST(1'b0)) dut_max (
        .clock(clock), .reset_n(reset_n), .start(start),
        .values(values6), .enable(enable6),
        .busy(busy_c), .done(done_c), .found(found_c),
        .min_index(idx_c), .min_value(val_c));

    min_index_seq #(.N(5), .W(8), .IW(3), .FIND_MAX(1'b0), .TIE_LAST(1'b0)) dut_n5 (
        .clock(clock), .reset_n(reset_n), .start(start5),
        .values(values5), .enable(enable5),
        .busy(busy_d), .done(done_d), .found(found_d),
        .min_index(idx_d), .min_value(val_d));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic f,
                           input logic [2:0] i, input logic [7:0] v,
                           input res_t e);
        chk({tag, "_found"}, {31'b0, f}, {31'b0, e.f});
        chk({tag, "_index"}, {29'b0, i}, {29'b0, e.i});
        chk({tag, "_value"}, {24'b0, v}, {24'b0, e.v});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: find the extreme value among enabled channels,
    // then pick the lowest or highest index holding it.
    function automatic res_t model(input bit fmax, input bit tlast,
                                   input int n, input logic [7:0] va[6],
                                   input logic [5:0] en);
        res_t r = '0;
        int best = -1;
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (en[i]) begin
                if (best < 0) best = int'(va[i]);
                else if (fmax && int'(va[i]) > best) best = int'(va[i]);
                else if (!fmax && int'(va[i]) < best) best = int'(va[i]);
            end
        end
        if (best < 0) return r;
        r.f = 1'b1;
        r.v = best[7:0];
        for (int i = 0; i < n; i++) begin
            if (en[i] && int'(va[i]) == best) begin
                if (tlast || !seen) r.i = i[2:0];
                seen = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [7:0] va[6], input logic [5:0] en);
        for (int i = 0; i < 6; i++) values6[i*8 +: 8] = va[i];
        for (int i = 0; i < 5; i++) values5[i*8 +: 8] = va[i];
        enable6 = en;
        enable5 = en[4:0];
    endtask

    task automatic rand_drive();
        logic [7:0] rv[6];
        for (int i = 0; i < 6; i++) rv[i] = 8'($urandom);
        drive(rv, 6'($urandom));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, {19'b0, busy_a, done_a, found_a, idx_a, val_a}, 0);
        chk({tag, "_b"}, {19'b0, busy_b, done_b, found_b, idx_b, val_b}, 0);
        chk({tag, "_c"}, {19'b0, busy_c, done_c, found_c, idx_c, val_c}, 0);
        chk({tag, "_d"}, {19'b0, busy_d, done_d, found_d, idx_d, val_d}, 0);
    endtask

    task automatic run_scan(input logic [7:0] va[6], input logic [5:0] en,
                            input bit glitch);
        res_t n_min, n_tie, n_max, n_n5;
        n_min = model(1'b0, 1'b0, 6, va, en);
        n_tie = model(1'b0, 1'b1, 6, va, en);
        n_max = model(1'b1, 1'b0, 6, va, en);
        n_n5  = model(1'b0, 1'b0, 5, va, en);
        drive(va, en);
        start = 1'b1;
        start5 = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (k == 0 || k == 3) begin
                start = 1'b0;
                start5 = 1'b0;
            end
            chk("busy6", {31'b0, busy_a}, {31'b0, k <= 5});
            chk("done6", {31'b0, done_a}, {31'b0, k == 6});
            chk("busy_tie", {31'b0, busy_b}, {31'b0, k <= 5});
            chk("done_max", {31'b0, done_c}, {31'b0, k == 6});
            chk("busy5", {31'b0, busy_d}, {31'b0, k <= 4});
            chk("done5", {31'b0, done_d}, {31'b0, k >= 5});
            if (k < 6) begin
                chk_res("hold_min", found_a, idx_a, val_a, e_min);
                chk_res("hold_tie", found_b, idx_b, val_b, e_tie);
                chk_res("hold_max", found_c, idx_c, val_c, e_max);
            end else begin
                chk_res("res_min", found_a, idx_a, val_a, n_min);
                chk_res("res_tie", found_b, idx_b, val_b, n_tie);
                chk_res("res_max", found_c, idx_c, val_c, n_max);
            end
            if (k < 5) chk_res("hold_n5", found_d, idx_d, val_d, e_n5);
            else chk_res("res_n5", found_d, idx_d, val_d, n_n5);
            if (glitch && k == 1) begin
                rand_drive();
                start = 1'b1;
                start5 = 1'b1;
            end
        end
        e_min = n_min;
        e_tie = n_tie;
        e_max = n_max;
        e_n5  = n_n5;
    endtask

    // start held in DONE: restart on the next edge, old result
    // stays visible until the new done, then back-to-back again.
    task automatic run_hold(input logic [7:0] va[6], input logic [5:0] en);
        res_t n_min, n_max;
        n_min = model(1'b0, 1'b0, 6, va, en);
        n_max = model(1'b1, 1'b0, 6, va, en);
        drive(va, en);
        start = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            chk("hbusy", {31'b0, busy_a}, {31'b0, k <= 5 || k == 7});
            chk("hdone", {31'b0, done_a}, {31'b0, k == 6});
            if (k < 6) begin
                chk_res("hold_old", found_a, idx_a, val_a, e_min);
            end else begin
                chk_res("hold_new", found_a, idx_a, val_a, n_min);
                chk_res("hold_newmax", found_c, idx_c, val_c, n_max);
            end
            chk("h_n5_idle", {31'b0, done_d}, 32'd1);
        end
        start = 1'b0;
        for (int k = 8; k <= 13; k++) begin
            tick();
            chk("b2b_done", {31'b0, done_a}, {31'b0, k == 13});
        end
        chk_res("b2b_res", found_a, idx_a, val_a, n_min);
        e_min = n_min;
        e_tie = model(1'b0, 1'b1, 6, va, en);
        e_max = n_max;
    endtask

    always @(negedge clock) begin
        if (reset_n && (busy_a || busy_d)) begin
            chk("cnt6_range", {31'b0, dut_min.cnt <= 3'd5}, 32'd1);
            chk("cnt5_range", {31'b0, dut_n5.cnt <= 3'd4}, 32'd1);
        end
        if (reset_n) begin
            chk("excl6", {31'b0, busy_a && done_a}, 32'd0);
            chk("excl5", {31'b0, busy_d && done_d}, 32'd0);
        end
    end

    initial begin
        logic [7:0] va[6];
        logic [7:0] rv[6];

        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all_zero("idle");
        end

        va = '{8'd40, 8'd12, 8'd99, 8'd12, 8'd7, 8'd50};
        run_scan(va, 6'b111111, 1'b0);
        chk("basic_idx", {29'b0, idx_a}, 32'd4);
        chk("basic_val", {24'b0, val_a}, 32'd7);

        run_scan(va, 6'b101111, 1'b0);
        chk("tie_first", {29'b0, idx_a}, 32'd1);
        chk("tie_val", {24'b0, val_a}, 32'd12);
        chk("tie_last", {29'b0, idx_b}, 32'd3);

        run_scan(va, 6'b000000, 1'b0);
        chk("none_found", {31'b0, found_a}, 32'd0);

        va = '{8'd3, 8'd200, 8'd200, 8'd9, 8'd0, 8'd1};
        run_scan(va, 6'b111111, 1'b0);
        chk("max_idx", {29'b0, idx_c}, 32'd1);
        chk("max_val", {24'b0, val_c}, 32'd200);

        va = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd0};
        run_scan(va, 6'b111111, 1'b1);
        chk("n5_idx", {29'b0, idx_d}, 32'd4);
        chk("n5_val", {24'b0, val_d}, 32'd5);

        va = '{8'd77, 8'd66, 8'd88, 8'd66, 8'd99, 8'd70};
        run_hold(va, 6'b111111);

        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 6; i++) begin
                rv[i] = (it % 2 == 0) ? 8'($urandom_range(0, 7))
                                      : 8'($urandom);
            end
            run_scan(rv, 6'($urandom), (it % 4) == 1);
        end

        va = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        drive(va, 6'b111111);
        start = 1'b1;
        start5 = 1'b1;
        tick();
        start = 1'b0;
        start5 = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_all_zero("post_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
